// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad hex-entry block.
//   scan_state_e : phases of one column strobe (drive, sample, hold)
//   KEYMAP       : [column][row] -> hex code, index 0 is C1 / R1
//   SEG7         : active-high {g..a} glyphs for hex digits 0..F
//   hex_to_seg7  : nibble -> active-high {dp,g..a}, dp always off
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN_DRIVE,
        SCAN_SAMPLE,
        SCAN_HOLD
    } scan_state_e;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'hF},
        '{4'h2, 4'h5, 4'h8, 4'h0},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    // Lower-case b and d keep B/8 and D/0 visually distinct.
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] hex_to_seg7(input logic [3:0] nibble);
        return {1'b0, SEG7[nibble]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debouncer producing one event per key press.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   frame_done_i   : one-cycle strobe at the end of each scan frame
//   res_valid_i    : frame saw exactly one key
//   res_code_i     : hex code of that key (ignored when res_valid_i is low)
//   key_valid_o    : one-cycle press event
//   key_code_o     : code of the last accepted key, held between events
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_done_i,
    input  logic       res_valid_i,
    input  logic [3:0] res_code_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int CNTW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBOUNCE_SCANS);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            lastValid_q, lastValid_d;
    logic [3:0]      lastCode_q, lastCode_d;
    logic            held_q, held_d;
    logic [3:0]      heldCode_q, heldCode_d;
    logic            keyValid_q, keyValid_d;
    logic [3:0]      keyCode_q, keyCode_d;
    logic            sameRes;

    // Two NONE results are identical regardless of the (meaningless) code.
    assign sameRes = (res_valid_i == lastValid_q) &&
                     (!res_valid_i || (res_code_i == lastCode_q));

    always_comb begin
        cnt_d       = cnt_q;
        lastValid_d = lastValid_q;
        lastCode_d  = lastCode_q;
        held_d      = held_q;
        heldCode_d  = heldCode_q;
        keyValid_d  = 1'b0;
        keyCode_d   = keyCode_q;
        if (frame_done_i) begin
            lastValid_d = res_valid_i;
            lastCode_d  = res_code_i;
            if (!sameRes) begin
                cnt_d = CNTW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNTW'(1);
            end
            // The counter saturates, so a stable held key cannot re-fire;
            // only a different key or a prior release re-arms acceptance.
            if (cnt_d == CNT_MAX) begin
                if (res_valid_i) begin
                    if (!held_q || (heldCode_q != res_code_i)) begin
                        held_d     = 1'b1;
                        heldCode_d = res_code_i;
                        keyValid_d = 1'b1;
                        keyCode_d  = res_code_i;
                    end
                end else begin
                    held_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            lastValid_q <= 1'b0;
            lastCode_q  <= '0;
            held_q      <= 1'b0;
            heldCode_q  <= '0;
            keyValid_q  <= 1'b0;
            keyCode_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            lastValid_q <= lastValid_d;
            lastCode_q  <= lastCode_d;
            held_q      <= held_d;
            heldCode_q  <= heldCode_d;
            keyValid_q  <= keyValid_d;
            keyCode_q   <= keyCode_d;
        end
    end

    assign key_valid_o = keyValid_q;
    assign key_code_o  = keyCode_q;

endmodule

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 keypad scanner, hex entry buffer, operand bank and
// 7-segment driver.
//   clk, rst     : clock, synchronous active-high reset
//   row / col    : active-low keypad rows in, one-hot active-low strobe out
//   op_sel       : operand index for commit
//   commit/clear : one-cycle control pulses (clear wins over commit)
//   key_valid    : one-cycle press event; key_code holds the last key
//   entry        : entry buffer, newest digit in [3:0]; entry_count digits
//   operand      : NUM_OPS operands of 4*DIGITS bits; op_valid per operand
//   seg_n        : registered active-low {dp,g..a} per digit, digit 0 low
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int COL_CYC        = 50000,
    parameter int SETTLE_CYC     = 8,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DIGITS         = 4,
    parameter int NUM_OPS        = 2,
    localparam int OPW           = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    row,
    output logic [3:0]                    col,
    input  logic [OPW-1:0]                op_sel,
    input  logic                          commit,
    input  logic                          clear,
    output logic                          key_valid,
    output logic [3:0]                    key_code,
    output logic [4*DIGITS-1:0]           entry,
    output logic [$clog2(DIGITS+1)-1:0]   entry_count,
    output logic [NUM_OPS*4*DIGITS-1:0]   operand,
    output logic [NUM_OPS-1:0]            op_valid,
    output logic [8*DIGITS-1:0]           seg_n
);

    localparam int W    = 4 * DIGITS;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int CYCW = $clog2(COL_CYC);
    localparam logic [CYCW-1:0] COL_LAST   = CYCW'(COL_CYC - 1);
    localparam logic [CYCW-1:0] SETTLE_PRE = CYCW'(SETTLE_CYC - 1);
    localparam logic [OPW:0]    NUM_OPS_L  = (OPW + 1)'(NUM_OPS);

    scan_state_e         state_q, state_d;
    logic [CYCW-1:0]     cyc_q, cyc_d;
    logic [1:0]          colIdx_q, colIdx_d;
    logic [3:0]          col_q, col_d;
    logic                hit_q, hit_d;
    logic                bad_q, bad_d;
    logic [3:0]          code_q, code_d;
    logic                frameDone;
    logic [3:0]          rowLow;
    logic [1:0]          rowIdx;
    logic                oneRow;

    logic [W-1:0]         entry_q, entry_d;
    logic [CW-1:0]        count_q, count_d;
    logic [NUM_OPS*W-1:0] operand_q, operand_d;
    logic [NUM_OPS-1:0]   opValid_q, opValid_d;
    logic [8*DIGITS-1:0]  seg_q, seg_d;
    logic                 commitOk;
    logic                 keyValid;
    logic [3:0]           keyCode;

    assign rowLow = ~row;
    assign oneRow = (rowLow != 4'd0) && ((rowLow & (rowLow - 4'd1)) == 4'd0);

    // row[3] is R1, so the row index counts down from the MSB.
    always_comb begin
        rowIdx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (rowLow[3-r]) rowIdx = 2'(r);
        end
    end

    // Each column: DRIVE for SETTLE_CYC cycles, one SAMPLE cycle, then HOLD
    // until COL_CYC cycles have elapsed. A frame result is valid only if a
    // single column showed a single low row and nothing else was pressed.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q + CYCW'(1);
        colIdx_d  = colIdx_q;
        col_d     = col_q;
        hit_d     = hit_q;
        bad_d     = bad_q;
        code_d    = code_q;
        frameDone = 1'b0;
        case (state_q)
            SCAN_DRIVE: begin
                if (cyc_q == SETTLE_PRE) state_d = SCAN_SAMPLE;
            end
            SCAN_SAMPLE: begin
                state_d = SCAN_HOLD;
                if ((rowLow != 4'd0 && !oneRow) || (oneRow && hit_q)) begin
                    bad_d = 1'b1;
                end else if (oneRow) begin
                    hit_d  = 1'b1;
                    code_d = KEYMAP[colIdx_q][rowIdx];
                end
            end
            SCAN_HOLD: begin
                if (cyc_q == COL_LAST) begin
                    state_d  = SCAN_DRIVE;
                    cyc_d    = '0;
                    colIdx_d = colIdx_q + 2'd1;
                    col_d    = ~(4'b1000 >> colIdx_d);
                    if (colIdx_q == 2'd3) begin
                        frameDone = 1'b1;
                        hit_d     = 1'b0;
                        bad_d     = 1'b0;
                    end
                end
            end
            default: state_d = SCAN_DRIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SCAN_DRIVE;
            cyc_q    <= '0;
            colIdx_q <= '0;
            col_q    <= 4'b0111;
            hit_q    <= 1'b0;
            bad_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            colIdx_q <= colIdx_d;
            col_q    <= col_d;
            hit_q    <= hit_d;
            bad_q    <= bad_d;
            code_q   <= code_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_i       (clk),
        .rst_i       (rst),
        .frame_done_i(frameDone),
        .res_valid_i (hit_q & ~bad_q),
        .res_code_i  (code_q),
        .key_valid_o (keyValid),
        .key_code_o  (keyCode)
    );

    // Out-of-range operand indices make the commit a no-op.
    assign commitOk = commit && ({1'b0, op_sel} < NUM_OPS_L);

    // clear > commit > key. A commit captures the pre-update entry; a key
    // arriving in the same cycle starts the fresh buffer.
    always_comb begin
        entry_d   = entry_q;
        count_d   = count_q;
        operand_d = operand_q;
        opValid_d = opValid_q;
        if (clear) begin
            entry_d = '0;
            count_d = '0;
        end else if (commitOk) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (op_sel == OPW'(k)) begin
                    operand_d[k*W +: W] = entry_q;
                    opValid_d[k]        = 1'b1;
                end
            end
            if (keyValid) begin
                entry_d = W'(keyCode);
                count_d = CW'(1);
            end else begin
                entry_d = '0;
                count_d = '0;
            end
        end else if (keyValid) begin
            entry_d = (entry_q << 4) | W'(keyCode);
            if (count_q != CW'(DIGITS)) count_d = count_q + CW'(1);
        end
    end

    // Digits beyond the entered count are blanked rather than showing 0.
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(count_q)) seg_d[i*8 +: 8] = ~hex_to_seg7(entry_q[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q   <= '0;
            count_q   <= '0;
            operand_q <= '0;
            opValid_q <= '0;
            seg_q     <= '1;
        end else begin
            entry_q   <= entry_d;
            count_q   <= count_d;
            operand_q <= operand_d;
            opValid_q <= opValid_d;
            seg_q     <= seg_d;
        end
    end

    assign col         = col_q;
    assign key_valid   = keyValid;
    assign key_code    = keyCode;
    assign entry       = entry_q;
    assign entry_count = count_q;
    assign operand     = operand_q;
    assign op_valid    = opValid_q;
    assign seg_n       = seg_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: scoreboard bench for keypad_hex_entry. A keypad model
// turns pressed-key masks into row levels from the column strobe; expected key
// events are queued as keys are pressed and a monitor pops them on key_valid.
module tb_keypad_hex_entry;

    localparam int COL_CYC        = 16;
    localparam int SETTLE_CYC     = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int DIGITS         = 4;
    localparam int NUM_OPS        = 2;
    localparam int FRAME          = 4 * COL_CYC;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        op_sel;
    logic        commit;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  entry_count;
    logic [31:0] operand;
    logic [1:0]  op_valid;
    logic [31:0] seg_n;

    logic [3:0][3:0] keyMask;
    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  count;
    } expEvent_t;

    expEvent_t expQ[$];

    keypad_hex_entry #(
        .COL_CYC       (COL_CYC),
        .SETTLE_CYC    (SETTLE_CYC),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .DIGITS        (DIGITS),
        .NUM_OPS       (NUM_OPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .op_sel     (op_sel),
        .commit     (commit),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry      (entry),
        .entry_count(entry_count),
        .operand    (operand),
        .op_valid   (op_valid),
        .seg_n      (seg_n)
    );

    // keyMask[c] bit 3 is R1, matching the row port ordering.
    function automatic logic [3:0] keypadRows(input logic [3:0] c, input logic [3:0][3:0] m);
        logic [3:0] r;
        r = 4'hF;
        case (c)
            4'b0111: r = ~m[0];
            4'b1011: r = ~m[1];
            4'b1101: r = ~m[2];
            4'b1110: r = ~m[3];
            default: r = 4'hF;
        endcase
        return r;
    endfunction

    // Returns {column index, row index} of a key, 0 = C1 / R1.
    function automatic logic [3:0] keyPos(input logic [3:0] code);
        case (code)
            4'h1: return 4'b00_00;  4'h4: return 4'b00_01;
            4'h7: return 4'b00_10;  4'hF: return 4'b00_11;
            4'h2: return 4'b01_00;  4'h5: return 4'b01_01;
            4'h8: return 4'b01_10;  4'h0: return 4'b01_11;
            4'h3: return 4'b10_00;  4'h6: return 4'b10_01;
            4'h9: return 4'b10_10;  4'hE: return 4'b10_11;
            4'hA: return 4'b11_00;  4'hB: return 4'b11_01;
            4'hC: return 4'b11_10;  default: return 4'b11_11;
        endcase
    endfunction

    assign row = keypadRows(col, keyMask);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pressMask(input logic [3:0] code);
        logic [3:0] p;
        p = keyPos(code);
        keyMask = '0;
        keyMask[p[3:2]] = 4'b1000 >> p[1:0];
    endtask

    // Press a key for holdFrames frames, release it for three frames so the
    // debouncer sees a full release. Queue the expected event if one is due.
    task automatic applyStimulus(input logic [3:0] code, input int holdFrames, input bit expectEvent,
                                 input logic [15:0] expEntry, input logic [2:0] expCount);
        if (expectEvent) expQ.push_back('{code: code, entry: expEntry, count: expCount});
        @(negedge clk);
        pressMask(code);
        repeat (holdFrames * FRAME) @(negedge clk);
        keyMask = '0;
        repeat (3 * FRAME) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst     = 1'b1;
        keyMask = '0;
        commit  = 1'b0;
        clear   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every key_valid must match the oldest queued event; the entry
    // registers update on the following edge.
    initial begin : monitor
        expEvent_t e;
        forever begin
            @(negedge clk);
            if (key_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedKeyValid", {63'd0, key_valid}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("keyCode", {60'd0, key_code}, {60'd0, e.code});
                    @(negedge clk);
                    checkOutput("entryAfterKey", {48'd0, entry}, {48'd0, e.entry});
                    checkOutput("countAfterKey", {61'd0, entry_count}, {61'd0, e.count});
                end
            end
        end
    end

    initial begin : main
        bit seen;
        rst     = 1'b1;
        op_sel  = 1'b0;
        commit  = 1'b0;
        clear   = 1'b0;
        keyMask = '0;

        // Reset state and column stepping
        resetDut();
        checkOutput("resetCol", {60'd0, col}, 64'h7);
        checkOutput("resetSeg", {32'd0, seg_n}, 64'hFFFF_FFFF);
        checkOutput("resetOpValid", {62'd0, op_valid}, 64'd0);
        checkOutput("resetKeyValid", {63'd0, key_valid}, 64'd0);
        checkOutput("resetKeyCode", {60'd0, key_code}, 64'd0);
        checkOutput("resetEntry", {48'd0, entry}, 64'd0);
        checkOutput("resetCount", {61'd0, entry_count}, 64'd0);
        checkOutput("resetOperand", {32'd0, operand}, 64'd0);
        repeat (COL_CYC) @(negedge clk);
        checkOutput("colC2", {60'd0, col}, 64'hB);
        repeat (COL_CYC) @(negedge clk);
        checkOutput("colC3", {60'd0, col}, 64'hD);
        repeat (COL_CYC) @(negedge clk);
        checkOutput("colC4", {60'd0, col}, 64'hE);
        repeat (COL_CYC) @(negedge clk);
        checkOutput("colWrap", {60'd0, col}, 64'h7);

        // Single key 2
        applyStimulus(4'h2, 4, 1'b1, 16'h0002, 3'd1);
        checkOutput("segKey2", {32'd0, seg_n}, 64'hFFFF_FFA4);

        // Five keys: buffer fills and the oldest digit falls off
        applyStimulus(4'h1, 4, 1'b1, 16'h0021, 3'd2);
        applyStimulus(4'h2, 4, 1'b1, 16'h0212, 3'd3);
        applyStimulus(4'h3, 4, 1'b1, 16'h2123, 3'd4);
        applyStimulus(4'h4, 4, 1'b1, 16'h1234, 3'd4);
        applyStimulus(4'h5, 4, 1'b1, 16'h2345, 3'd4);
        checkOutput("entryFull", {48'd0, entry}, 64'h2345);
        checkOutput("countSat", {61'd0, entry_count}, 64'd4);
        checkOutput("segFull", {32'd0, seg_n}, 64'hA4B0_9992);

        // Two keys at once, then a one-frame bounce: neither may fire
        @(negedge clk);
        keyMask[0] = 4'b1000;
        keyMask[1] = 4'b1000;
        repeat (4 * FRAME) @(negedge clk);
        keyMask = '0;
        repeat (3 * FRAME) @(negedge clk);
        applyStimulus(4'h9, 1, 1'b0, 16'h0, 3'd0);
        checkOutput("entryAfterReject", {48'd0, entry}, 64'h2345);

        // Clear, enter A B, then commit coinciding with key C
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checkOutput("clearEntry", {48'd0, entry}, 64'd0);
        checkOutput("clearCount", {61'd0, entry_count}, 64'd0);
        checkOutput("clearSeg", {32'd0, seg_n}, 64'hFFFF_FFFF);
        applyStimulus(4'hA, 4, 1'b1, 16'h000A, 3'd1);
        applyStimulus(4'hB, 4, 1'b1, 16'h00AB, 3'd2);
        expQ.push_back('{code: 4'hC, entry: 16'h000C, count: 3'd1});
        pressMask(4'hC);
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (key_valid) begin
                seen   = 1'b1;
                commit = 1'b1;
                op_sel = 1'b1;
            end
        end
        if (!seen) checkOutput("keyValidTimeout", {63'd0, key_valid}, 64'd1);
        @(negedge clk);
        commit = 1'b0;
        repeat (FRAME) @(negedge clk);
        keyMask = '0;
        repeat (3 * FRAME) @(negedge clk);
        checkOutput("operand1", {48'd0, operand[31:16]}, 64'h00AB);
        checkOutput("operand0Idle", {48'd0, operand[15:0]}, 64'd0);
        checkOutput("opValid10", {62'd0, op_valid}, 64'h2);
        checkOutput("entryAfterCommitKey", {48'd0, entry}, 64'h000C);
        checkOutput("segAfterCommitKey", {32'd0, seg_n}, 64'hFFFF_FFC6);

        // Plain commit into operand 0 clears the entry
        applyStimulus(4'h7, 4, 1'b1, 16'h00C7, 3'd2);
        @(negedge clk);
        commit = 1'b1;
        op_sel = 1'b0;
        @(negedge clk);
        commit = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("operand0", {48'd0, operand[15:0]}, 64'h00C7);
        checkOutput("opValid11", {62'd0, op_valid}, 64'h3);
        checkOutput("commitClearsEntry", {48'd0, entry}, 64'd0);
        checkOutput("commitClearsCount", {61'd0, entry_count}, 64'd0);
        checkOutput("segAfterCommit", {32'd0, seg_n}, 64'hFFFF_FFFF);

        // clear beats a same-cycle commit
        applyStimulus(4'h9, 4, 1'b1, 16'h0009, 3'd1);
        @(negedge clk);
        clear  = 1'b1;
        commit = 1'b1;
        op_sel = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        commit = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("clearWinsEntry", {48'd0, entry}, 64'd0);
        checkOutput("clearWinsOperand1", {48'd0, operand[31:16]}, 64'h00AB);
        checkOutput("clearWinsOperand0", {48'd0, operand[15:0]}, 64'h00C7);
        checkOutput("clearWinsOpValid", {62'd0, op_valid}, 64'h3);

        // Reset mid-debounce: key 1 seen in one completed frame and sampled
        // again before the second frame ends, then reset discards it.
        resetDut();
        pressMask(4'h1);
        repeat (100) @(negedge clk);
        rst     = 1'b1;
        keyMask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetCol", {60'd0, col}, 64'h7);
        checkOutput("midResetOpValid", {62'd0, op_valid}, 64'd0);
        repeat (5 * FRAME) @(negedge clk);
        checkOutput("midResetEntry", {48'd0, entry}, 64'd0);
        checkOutput("midResetKeyCode", {60'd0, key_code}, 64'd0);

        checkOutput("pendingEvents", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
